// File: rtl/byte_serial_add_pkg.sv
// Shared types and constants for the byte-serial adder sequencer.
package byte_serial_add_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/byte_add8.sv
// Combinational 8-bit ripple-carry adder built from a chain of full adders.
module byte_add8
  import byte_serial_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic c;

  always_comb begin
    c = cin;
    s = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Adds two NBYTES-wide operands one byte per clock through a single shared 8-bit adder.
// Define BYTE_SERIAL_ADD_SUB_EN to add the 'sub' port (a - b via inverted B and carry-in 1).
module byte_serial_add_ctrl
  import byte_serial_add_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NBYTES*BYTE_W-1:0] a,
  input  logic [NBYTES*BYTE_W-1:0] b,
`ifdef BYTE_SERIAL_ADD_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [NBYTES*BYTE_W-1:0] sum,
  output logic                     cout
);

  localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] IdxLast = IDXW'(NBYTES - 1);

  state_e                          state_q, state_d;
  logic [IDXW-1:0]                 idx_q, idx_d;
  logic                            carry_q, carry_d;
  logic                            cout_q, cout_d;
  logic [NBYTES-1:0][BYTE_W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                            sub_q, sub_d;
  logic [BYTE_W-1:0]               add_a, add_b, add_s;
  logic                            add_co;

`ifdef BYTE_SERIAL_ADD_SUB_EN
  logic sub_in;
  assign sub_in = sub;
`else
  logic sub_in;
  assign sub_in = 1'b0;
`endif

  // Subtraction feeds the one's complement of B; the +1 comes from the initial carry.
  assign add_a = a_q[idx_q];
  assign add_b = b_q[idx_q] ^ {BYTE_W{sub_q}};

  byte_add8 u_byte_add8 (
    .a   (add_a),
    .b   (add_b),
    .cin (carry_q),
    .s   (add_s),
    .co  (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in;
          idx_d   = '0;
          carry_d = sub_in;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q] = add_s;
        carry_d      = add_co;
        if (idx_q == IdxLast) begin
          cout_d  = add_co;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/byte_serial_add_ctrl.md
Name: byte_serial_add_ctrl

Overview:
- Sequencer that adds two NBYTES-wide operands using one 8-bit adder, time-shared across bytes.
- Processes one byte per clock, LSB first, and carries between bytes through a registered carry.
- Sits between a requester (start/busy/done handshake) and the 8-bit adder datapath.
- Trades latency for area versus a full-width ripple adder.

Parameters:
- NBYTES, 4, number of 8-bit bytes per operand; legal range 2..16.
- IDXW, $clog2(NBYTES), width of the byte index counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only while idle.
- a  input  8*NBYTES  operand A; captured on accepted start.
- b  input  8*NBYTES  operand B; captured on accepted start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse when sum/cout are final.
- sum  output  8*NBYTES  result; held stable from done until next accepted start.
- cout  output  1  carry out of the MSB byte; held with sum.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, idx=0, operand registers=0. Reset overrides all other inputs, including mid-RUN; a partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge -> capture a and b into internal registers, idx=0, carry=0 (1 when SUBTRACT_EN and sub=1), go to RUN.
  - sum and cout keep their previous values until the first byte write.
- RUN, at each edge:
  - sum byte[idx] = a_r byte[idx] + b_r byte[idx] + carry, modulo 256; carry = bit 8 of that addition.
  - If idx==NBYTES-1: cout = new carry, go to DONE. Otherwise idx = idx+1.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE with done=0.
- Latency: start accepted at edge k -> done high in the cycle after edge k+NBYTES. Back-to-back throughput is one operation per NBYTES+2 cycles.
- start while busy=1 is ignored. No queuing, no error flag. Input a/b changes while busy have no effect.
- start asserted in the same cycle that done is high is ignored, because the state is DONE, not IDLE.
- Arithmetic is unsigned modulo 2^(8*NBYTES). cout reports overflow. Intermediate sum bytes are visible during RUN and are not valid until done.
- Wrap: idx never exceeds NBYTES-1. idx resets to 0 on each accepted start.

Optional Feature:
- Macro: BYTE_SERIAL_ADD_SUB_EN.
- Defined:
  - Adds port sub (input, 1), captured with start.
  - sub=1 computes a-b: each B byte is inverted before the adder, and the initial carry is 1.
  - cout=1 means no borrow (a>=b); cout=0 means borrow.
  - sub=0 behaves exactly as addition.
- Undefined: no sub port. Addition only, initial carry always 0.

Decomposition:
- Shared package/include (byte_serial_add_pkg.vh):
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - BYTE_W=8;
  - default NBYTES constant.
- One sub-module: byte_add8.
  - Purely combinational 8-bit adder: a[7:0], b[7:0], cin -> s[7:0], co.
  - Built as a ripple chain of full adders, consistent with the existing adder datapath.
  - Instantiated once; the controller muxes operand bytes by idx.

Test Plan (NBYTES=4 unless noted):
- Carry across a byte boundary: a=0x000000FF, b=0x00000001, start -> done exactly 5 cycles after the start edge (4 RUN + 1), sum=0x00000100, cout=0, busy high for 5 cycles.
- Full overflow: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1. Then a=0x12345678, b=0x11111111 -> sum=0x23456789, cout=0.
- Ignored start: second start at cycle 2 of RUN, with a=0xAAAAAAAA -> the first result completes unchanged; exactly one done pulse. Another start in the done cycle is also ignored.
- Reset mid-operation: rst=1 during RUN idx=2 -> next cycle busy=0, done=0, sum=0, cout=0. A new start then yields the correct result with no stale carry.
- Subtraction (BYTE_SERIAL_ADD_SUB_EN): sub=1, a=5, b=10 -> sum=0xFFFFFFFB, cout=0. sub=1, a=10, b=5 -> sum=0x00000005, cout=1.
- Parameter sweep: NBYTES=2, a=0xFFFF, b=0xFFFF -> sum=0xFFFE, cout=1, done 3 cycles after start; random compare against a reference model of 1000 operations.
